// File: rtl/multi_channel_run_controller_if.sv
// Interface bundling the per-channel command inputs and status outputs of
// multi_channel_run_controller.
//   master : command/tick source (drives i_*, observes o_*)
//   slave  : the controller (observes i_*, drives o_*)
// Signals:
//   i_tick          shared one-cycle count enable from the prescaler
//   i_soft_reset    per-channel synchronous clear
//   i_trigger_run   per-channel start/resume request
//   i_trigger_halt  per-channel pause request
//   i_lap           per-channel lap capture request
//   o_enable_sig    per-channel "OPERATING" flag
//   o_state         channel k state at [2k+1:2k]
//   o_count         channel k elapsed count at [CNT_W*k +: CNT_W]
//   o_lap_count     channel k captured lap value at [CNT_W*k +: CNT_W]
//   o_lap_valid     one-cycle pulse after a lap capture
//   o_expired       per-channel "EXPIRED" flag
//   o_wrap_pulse    one-cycle pulse after a counter wrap
interface multi_channel_run_controller_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic                    i_tick;
  logic [N_CH-1:0]         i_soft_reset;
  logic [N_CH-1:0]         i_trigger_run;
  logic [N_CH-1:0]         i_trigger_halt;
  logic [N_CH-1:0]         i_lap;
  logic [N_CH-1:0]         o_enable_sig;
  logic [2*N_CH-1:0]       o_state;
  logic [CNT_W*N_CH-1:0]   o_count;
  logic [CNT_W*N_CH-1:0]   o_lap_count;
  logic [N_CH-1:0]         o_lap_valid;
  logic [N_CH-1:0]         o_expired;
  logic [N_CH-1:0]         o_wrap_pulse;

  modport master (
    output i_tick, i_soft_reset, i_trigger_run, i_trigger_halt, i_lap,
    input  o_enable_sig, o_state, o_count, o_lap_count, o_lap_valid,
           o_expired, o_wrap_pulse
  );

  modport slave (
    input  i_tick, i_soft_reset, i_trigger_run, i_trigger_halt, i_lap,
    output o_enable_sig, o_state, o_count, o_lap_count, o_lap_valid,
           o_expired, o_wrap_pulse
  );
endinterface

// File: rtl/multi_channel_run_controller.sv
// N_CH independent stopwatch run/halt channels. Each channel owns a
// READY/OPERATING/SUSPENDED/EXPIRED state machine, an elapsed-tick counter
// paced by the shared i_tick enable, a lap-capture register and terminal
// count handling (halt-and-expire, or wrap with a pulse when AUTO_WRAP=1).
// Ports:
//   i_clock        system clock, rising edge
//   i_async_rst_n  asynchronous active-low reset
//   bus            slave side of multi_channel_run_controller_if
module multi_channel_run_controller #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int TERM_COUNT = 9999,
  parameter int AUTO_WRAP  = 0
) (
  input  logic                            i_clock,
  input  logic                            i_async_rst_n,
  multi_channel_run_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    READY     = 2'b00,
    OPERATING = 2'b01,
    SUSPENDED = 2'b10,
    EXPIRED   = 2'b11
  } state_t;

  // Widths of 31 and above always hold a non-negative int TERM_COUNT.
  if (TERM_COUNT < 0 || (CNT_W < 31 && TERM_COUNT >= (1 << CNT_W))) begin : g_bad_term
    $error("TERM_COUNT must lie in [0, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERM_COUNT);

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] lap_q   [N_CH];
  logic [CNT_W-1:0] lap_d   [N_CH];
  logic [N_CH-1:0]  lap_vld_q, lap_vld_d;
  logic [N_CH-1:0]  wrap_q, wrap_d;

  always_ff @(posedge i_clock or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= READY;
        cnt_q[k]   <= '0;
        lap_q[k]   <= '0;
      end
      lap_vld_q <= '0;
      wrap_q    <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        lap_q[k]   <= lap_d[k];
      end
      lap_vld_q <= lap_vld_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    lap_vld_d = '0;
    wrap_d    = '0;
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      lap_d[k]   = lap_q[k];

      if (bus.i_soft_reset[k]) begin
        state_d[k] = READY;
        cnt_d[k]   = '0;
        lap_d[k]   = '0;
      end else begin
        case (state_q[k])
          READY: begin
            if (bus.i_trigger_run[k]) state_d[k] = OPERATING;
          end
          OPERATING: begin
            // The tick still counts in the cycle a halt arrives.
            if (bus.i_tick && cnt_q[k] == TERM_VAL) begin
              if (AUTO_WRAP == 0) begin
                state_d[k] = EXPIRED;  // expiry beats a simultaneous halt
              end else begin
                cnt_d[k]  = '0;
                wrap_d[k] = 1'b1;
                if (bus.i_trigger_halt[k]) state_d[k] = SUSPENDED;
              end
            end else begin
              if (bus.i_tick) cnt_d[k] = cnt_q[k] + CNT_W'(1);
              if (bus.i_trigger_halt[k]) state_d[k] = SUSPENDED;
            end
          end
          SUSPENDED: begin
            if (bus.i_trigger_run[k]) state_d[k] = OPERATING;
          end
          default: ;  // EXPIRED: only a reset leaves
        endcase

        // Lap takes the pre-increment count, so a wrapping cycle yields TERM_COUNT.
        if (bus.i_lap[k] && state_q[k] != READY) begin
          lap_d[k]     = cnt_q[k];
          lap_vld_d[k] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign bus.o_state[2*k +: 2]             = state_q[k];
    assign bus.o_count[CNT_W*k +: CNT_W]     = cnt_q[k];
    assign bus.o_lap_count[CNT_W*k +: CNT_W] = lap_q[k];
    assign bus.o_enable_sig[k]               = (state_q[k] == OPERATING);
    assign bus.o_expired[k]                  = (state_q[k] == EXPIRED);
  end

  assign bus.o_lap_valid  = lap_vld_q;
  assign bus.o_wrap_pulse = wrap_q;

endmodule

// File: tb/tb_multi_channel_run_controller.sv
// Directed bench: u_dut0 uses AUTO_WRAP=0, u_dut1 uses AUTO_WRAP=1, both
// with N_CH=2, CNT_W=8, TERM_COUNT=5.
module tb_multi_channel_run_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multi_channel_run_controller_if #(.N_CH(2), .CNT_W(8)) b0 ();
  multi_channel_run_controller_if #(.N_CH(2), .CNT_W(8)) b1 ();

  multi_channel_run_controller #(
    .N_CH(2), .CNT_W(8), .TERM_COUNT(5), .AUTO_WRAP(0)
  ) u_dut0 (
    .i_clock(clk), .i_async_rst_n(rst_n), .bus(b0)
  );

  multi_channel_run_controller #(
    .N_CH(2), .CNT_W(8), .TERM_COUNT(5), .AUTO_WRAP(1)
  ) u_dut1 (
    .i_clock(clk), .i_async_rst_n(rst_n), .bus(b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.i_tick = 1'b0; b0.i_soft_reset = '0; b0.i_trigger_run = '0;
    b0.i_trigger_halt = '0; b0.i_lap = '0;
    b1.i_tick = 1'b0; b1.i_soft_reset = '0; b1.i_trigger_run = '0;
    b1.i_trigger_halt = '0; b1.i_lap = '0;
  endtask

  task automatic clear_all();
    b0.i_soft_reset = '1;
    b1.i_soft_reset = '1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset();
    checks++;
    if ({b0.o_state, b0.o_count, b0.o_lap_count} !== '0) begin
      failures++;
      $display("FAIL reset_dut0_regs: got %0h required 0", {b0.o_state, b0.o_count, b0.o_lap_count});
    end
    checks++;
    if ({b0.o_lap_valid, b0.o_expired, b0.o_wrap_pulse, b0.o_enable_sig} !== '0) begin
      failures++;
      $display("FAIL reset_dut0_flags: got %0h required 0", {b0.o_lap_valid, b0.o_expired, b0.o_wrap_pulse, b0.o_enable_sig});
    end
    checks++;
    if ({b1.o_state, b1.o_count, b1.o_lap_count, b1.o_lap_valid, b1.o_wrap_pulse} !== '0) begin
      failures++;
      $display("FAIL reset_dut1: got %0h required 0", {b1.o_state, b1.o_count, b1.o_lap_count, b1.o_lap_valid, b1.o_wrap_pulse});
    end
  endtask

  task automatic test_expire();
    clear_all();
    b0.i_trigger_run = 2'b01;
    cyc();
    b0.i_trigger_run = 2'b00;
    checks++;
    if (b0.o_state[1:0] !== 2'b01 || b0.o_enable_sig[0] !== 1'b1) begin
      failures++;
      $display("FAIL expire_start: got state %b en %b required 01/1", b0.o_state[1:0], b0.o_enable_sig[0]);
    end
    b0.i_tick = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (b0.o_count[7:0] !== 8'(i) || b0.o_state[1:0] !== 2'b01) begin
        failures++;
        $display("FAIL expire_count%0d: got count %0d state %b required %0d/01", i, b0.o_count[7:0], b0.o_state[1:0], i);
      end
    end
    cyc();
    b0.i_tick = 1'b0;
    checks++;
    if (b0.o_count[7:0] !== 8'd5 || b0.o_state[1:0] !== 2'b11 || b0.o_expired[0] !== 1'b1) begin
      failures++;
      $display("FAIL expire_term: got count %0d state %b exp %b required 5/11/1", b0.o_count[7:0], b0.o_state[1:0], b0.o_expired[0]);
    end
    b0.i_trigger_run = 2'b01;
    b0.i_tick = 1'b1;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_tick = 1'b0;
    checks++;
    if (b0.o_state[1:0] !== 2'b11 || b0.o_count[7:0] !== 8'd5 || b0.o_enable_sig[0] !== 1'b0) begin
      failures++;
      $display("FAIL expire_run_ignored: got state %b count %0d required 11/5", b0.o_state[1:0], b0.o_count[7:0]);
    end
    checks++;
    if (b0.o_state[3:2] !== 2'b00 || b0.o_count[15:8] !== 8'd0) begin
      failures++;
      $display("FAIL expire_ch1_idle: got state %b count %0d required 00/0", b0.o_state[3:2], b0.o_count[15:8]);
    end
  endtask

  task automatic test_wrap();
    clear_all();
    b1.i_trigger_run = 2'b10;
    cyc();
    b1.i_trigger_run = 2'b00;
    b1.i_tick = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++;
      if (b1.o_count[15:8] !== 8'(i % 6) || b1.o_wrap_pulse[1] !== (i == 6) || b1.o_state[3:2] !== 2'b01) begin
        failures++;
        $display("FAIL wrap_step%0d: got count %0d wrap %b state %b required %0d/%0d/01", i, b1.o_count[15:8], b1.o_wrap_pulse[1], b1.o_state[3:2], i % 6, (i == 6));
      end
    end
    b1.i_tick = 1'b0;
    cyc();
    checks++;
    if (b1.o_wrap_pulse[1] !== 1'b0 || b1.o_count[15:8] !== 8'd0 || b1.o_state[3:2] !== 2'b01) begin
      failures++;
      $display("FAIL wrap_pulse_end: got wrap %b count %0d state %b required 0/0/01", b1.o_wrap_pulse[1], b1.o_count[15:8], b1.o_state[3:2]);
    end
    b1.i_tick = 1'b1;
    repeat (5) cyc();
    b1.i_lap = 2'b10;
    cyc();
    b1.i_lap = 2'b00;
    b1.i_tick = 1'b0;
    checks++;
    if (b1.o_lap_count[15:8] !== 8'd5 || b1.o_lap_valid[1] !== 1'b1 || b1.o_count[15:8] !== 8'd0 || b1.o_wrap_pulse[1] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_lap: got lap %0d lv %b count %0d wrap %b required 5/1/0/1", b1.o_lap_count[15:8], b1.o_lap_valid[1], b1.o_count[15:8], b1.o_wrap_pulse[1]);
    end
  endtask

  task automatic test_halt_priority();
    clear_all();
    b0.i_trigger_run = 2'b01;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_tick = 1'b1;
    repeat (3) cyc();
    b0.i_trigger_run = 2'b01;
    b0.i_trigger_halt = 2'b01;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_trigger_halt = 2'b00;
    checks++;
    if (b0.o_count[7:0] !== 8'd4 || b0.o_state[1:0] !== 2'b10 || b0.o_enable_sig[0] !== 1'b0) begin
      failures++;
      $display("FAIL halt_wins: got count %0d state %b en %b required 4/10/0", b0.o_count[7:0], b0.o_state[1:0], b0.o_enable_sig[0]);
    end
    cyc();
    checks++;
    if (b0.o_count[7:0] !== 8'd4) begin
      failures++;
      $display("FAIL halt_tick_ignored: got %0d required 4", b0.o_count[7:0]);
    end
    b0.i_tick = 1'b0;
    b0.i_trigger_run = 2'b01;
    cyc();
    b0.i_trigger_run = 2'b00;
    checks++;
    if (b0.o_state[1:0] !== 2'b01 || b0.o_enable_sig[0] !== 1'b1) begin
      failures++;
      $display("FAIL halt_resume: got state %b en %b required 01/1", b0.o_state[1:0], b0.o_enable_sig[0]);
    end
    clear_all();
    b0.i_trigger_run = 2'b10;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_tick = 1'b1;
    repeat (5) cyc();
    b0.i_trigger_halt = 2'b10;
    cyc();
    b0.i_trigger_halt = 2'b00;
    b0.i_tick = 1'b0;
    checks++;
    if (b0.o_state[3:2] !== 2'b11 || b0.o_count[15:8] !== 8'd5 || b0.o_expired[1] !== 1'b1) begin
      failures++;
      $display("FAIL expire_over_halt: got state %b count %0d exp %b required 11/5/1", b0.o_state[3:2], b0.o_count[15:8], b0.o_expired[1]);
    end
  endtask

  task automatic test_lap();
    clear_all();
    b0.i_trigger_run = 2'b01;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_tick = 1'b1;
    repeat (2) cyc();
    b0.i_lap = 2'b01;
    cyc();
    b0.i_lap = 2'b00;
    b0.i_tick = 1'b0;
    checks++;
    if (b0.o_lap_count[7:0] !== 8'd2 || b0.o_lap_valid[0] !== 1'b1 || b0.o_count[7:0] !== 8'd3) begin
      failures++;
      $display("FAIL lap_capture: got lap %0d lv %b count %0d required 2/1/3", b0.o_lap_count[7:0], b0.o_lap_valid[0], b0.o_count[7:0]);
    end
    cyc();
    checks++;
    if (b0.o_lap_valid[0] !== 1'b0 || b0.o_lap_count[7:0] !== 8'd2) begin
      failures++;
      $display("FAIL lap_pulse_end: got lv %b lap %0d required 0/2", b0.o_lap_valid[0], b0.o_lap_count[7:0]);
    end
    b0.i_lap = 2'b10;
    cyc();
    b0.i_lap = 2'b00;
    checks++;
    if (b0.o_lap_valid[1] !== 1'b0 || b0.o_lap_count[15:8] !== 8'd0) begin
      failures++;
      $display("FAIL lap_ready_ignored: got lv %b lap %0d required 0/0", b0.o_lap_valid[1], b0.o_lap_count[15:8]);
    end
  endtask

  task automatic test_soft_reset();
    clear_all();
    b0.i_trigger_run = 2'b11;
    cyc();
    b0.i_trigger_run = 2'b00;
    b0.i_tick = 1'b1;
    repeat (4) cyc();
    b0.i_tick = 1'b0;
    b0.i_lap = 2'b01;
    cyc();
    b0.i_lap = 2'b00;
    b0.i_soft_reset = 2'b01;
    b0.i_tick = 1'b1;
    b0.i_trigger_run = 2'b01;
    b0.i_lap = 2'b01;
    cyc();
    idle_inputs();
    checks++;
    if (b0.o_state[1:0] !== 2'b00 || b0.o_count[7:0] !== 8'd0 || b0.o_lap_count[7:0] !== 8'd0 || b0.o_lap_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL soft_reset_ch0: got state %b count %0d lap %0d lv %b required 00/0/0/0", b0.o_state[1:0], b0.o_count[7:0], b0.o_lap_count[7:0], b0.o_lap_valid[0]);
    end
    checks++;
    if (b0.o_state[3:2] !== 2'b01 || b0.o_count[15:8] !== 8'd5) begin
      failures++;
      $display("FAIL soft_reset_ch1: got state %b count %0d required 01/5", b0.o_state[3:2], b0.o_count[15:8]);
    end
  endtask

  task automatic test_async_reset();
    clear_all();
    b1.i_trigger_run = 2'b01;
    cyc();
    b1.i_trigger_run = 2'b00;
    b1.i_tick = 1'b1;
    cyc();
    b1.i_lap = 2'b01;
    cyc();
    b1.i_lap = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b1.o_count[7:0] !== 8'd0 || b1.o_state[1:0] !== 2'b00 || b1.o_lap_count[7:0] !== 8'd0 || b1.o_lap_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_clear_dut1: got count %0d state %b lap %0d lv %b required 0/00/0/0", b1.o_count[7:0], b1.o_state[1:0], b1.o_lap_count[7:0], b1.o_lap_valid[0]);
    end
    checks++;
    if ({b0.o_state, b0.o_count, b0.o_lap_count, b0.o_expired, b0.o_enable_sig} !== '0) begin
      failures++;
      $display("FAIL async_clear_dut0: got %0h required 0", {b0.o_state, b0.o_count, b0.o_lap_count, b0.o_expired, b0.o_enable_sig});
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    b1.i_tick = 1'b0;
    b1.i_trigger_run = 2'b01;
    cyc();
    b1.i_trigger_run = 2'b00;
    b1.i_tick = 1'b1;
    cyc();
    b1.i_tick = 1'b0;
    checks++;
    if (b1.o_count[7:0] !== 8'd1 || b1.o_state[1:0] !== 2'b01) begin
      failures++;
      $display("FAIL async_restart: got count %0d state %b required 1/01", b1.o_count[7:0], b1.o_state[1:0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    #11;
    rst_n = 1'b1;
    cyc();
    test_expire();
    test_wrap();
    test_halt_priority();
    test_lap();
    test_soft_reset();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_run_controller.md
Name: multi_channel_run_controller

Overview:
- Parametrised successor to the single-channel stopwatch run/halt FSM.
- Provides N_CH independent channels. Each channel has a READY/OPERATING/SUSPENDED/EXPIRED state machine, an elapsed-tick counter, a lap-capture register and terminal-count handling.
- Sits between the debounced button/command decode and the display/BCD formatting logic.
- Counting is paced by a shared prescaled tick enable.

Parameters:
- N_CH, 4: number of independent channels.
- CNT_W, 16: width of each channel's elapsed counter and lap register.
- TERM_COUNT, 9999: terminal count value. Must be < 2^CNT_W; this is enforced by an elaboration-time check.
- AUTO_WRAP, 0: 0 = channel halts at TERM_COUNT and enters EXPIRED; 1 = counter wraps to 0 and emits a wrap pulse.

Ports:
- i_clock  in  1  single system clock; all state updates on its rising edge.
- i_async_rst_n  in  1  asynchronous, active-low reset.
- i_tick  in  1  shared count enable, one-cycle pulse from the prescaler.
- i_soft_reset  in  N_CH  per-channel synchronous clear.
- i_trigger_run  in  N_CH  per-channel start/resume request.
- i_trigger_halt  in  N_CH  per-channel pause request.
- i_lap  in  N_CH  per-channel lap capture request.
- o_enable_sig  out  N_CH  high while the channel is OPERATING.
- o_state  out  2*N_CH  channel k state at bits [2k+1:2k].
- o_count  out  CNT_W*N_CH  channel k elapsed count at bits [CNT_W*k +: CNT_W].
- o_lap_count  out  CNT_W*N_CH  channel k captured lap value.
- o_lap_valid  out  N_CH  one-cycle pulse when the lap register is updated.
- o_expired  out  N_CH  high while the channel is in EXPIRED.
- o_wrap_pulse  out  N_CH  one-cycle pulse when the counter wraps (AUTO_WRAP=1 only).

Behaviour:
- Reset: i_async_rst_n low immediately forces, without waiting for a clock edge:
  - all states = READY (2'b00);
  - o_count = 0, o_lap_count = 0;
  - o_lap_valid, o_wrap_pulse and o_expired all 0.
  - Reset is released on the first clock edge after deassertion.
- State encoding: READY = 00, OPERATING = 01, SUSPENDED = 10, EXPIRED = 11.
- Per-channel transitions, evaluated in this priority order:
  - i_soft_reset (any state) -> READY. Same cycle: count = 0, lap = 0, pulses suppressed. Overrides tick, run, halt and lap.
  - READY: run -> OPERATING; halt ignored.
  - OPERATING: halt -> SUSPENDED. Halt wins over a simultaneous run.
  - SUSPENDED: run -> OPERATING; halt ignored.
  - EXPIRED: run and halt ignored; only soft reset or async reset exits.
- o_enable_sig and o_expired are combinational decodes of the registered state.
- Counting is qualified by the registered state:
  - count increments when state == OPERATING and i_tick = 1;
  - this includes the cycle in which halt arrives; the halt takes effect from the next cycle.
  - A tick in any other state does nothing.
- Terminal count, in a qualified tick cycle with count == TERM_COUNT:
  - AUTO_WRAP = 0: count holds at TERM_COUNT, state -> EXPIRED; the expiry transition has priority over a simultaneous halt.
  - AUTO_WRAP = 1: count -> 0, o_wrap_pulse = 1 for exactly the next cycle, state stays OPERATING (or goes to SUSPENDED if halt was asserted).
  - TERM_COUNT = 0 is legal: every qualified tick wraps or expires.
- Lap capture:
  - i_lap in OPERATING, SUSPENDED or EXPIRED loads o_lap_count with the pre-increment count of that same cycle.
  - o_lap_valid pulses high the following cycle.
  - Lap requests in READY are ignored.
  - A lap coinciding with a wrap captures TERM_COUNT.
- Channels are fully independent; no cross-channel priority or sharing.
- All arithmetic is unsigned, CNT_W bits; no overflow is possible beyond TERM_COUNT.

Test Plan (N_CH=2, CNT_W=8, TERM_COUNT=5):
1. AUTO_WRAP=0. Run ch0, apply 6 ticks -> o_count[7:0] goes 1..5, then o_state[1:0]=11 and o_expired[0]=1. A later run has no effect; ch1 stays READY with count 0.
2. AUTO_WRAP=1. Run ch1, apply 6 ticks -> count goes 1,2,3,4,5,0 and o_wrap_pulse[1] is high for one cycle after the 6th tick. State stays 01.
3. Ch0 OPERATING at count 3. Drive run+halt+tick in the same cycle -> next cycle count=4 and state=10. Then run -> state=01 and enable=1.
4. Ch0 count 2 with lap+tick in the same cycle -> o_lap_count=2, o_lap_valid pulses for one cycle, count=3. A lap issued in READY leaves o_lap_valid=0.
5. Soft reset on ch0 together with tick and run while OPERATING at count 4 -> state 00, count 0, lap 0; ch1 is unaffected.
6. Assert i_async_rst_n low mid-count, off the clock edge -> all outputs clear immediately. After release, the first run+tick gives count=1.
